// File: rtl/decode_stage_if.sv
// Handshake and field bundle between fetch, decode_stage and the register file / ALU side.
// master drives the upstream fields, writeback retire and downstream ready; slave is the stage.
interface decode_stage_if #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned REG_W = $clog2(NREGS);

    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  rsrc_in;
    logic [REG_W-1:0]  rdst_in;
    logic [IMM_W-1:0]  imm_in;
    logic [3:0]        flag_type;
    logic [1:0]        imm_mode;
    logic              wr_done_valid;
    logic [REG_W-1:0]  wr_done_idx;
    logic              out_valid;
    logic              out_ready;
    logic [REG_W:0]    rsrc_sel;
    logic [REG_W:0]    rdst_sel;
    logic [NREGS-1:0]  rdst_wen;
    logic [DATA_W-1:0] imm_out;
    logic              stall_hazard;
    logic [NREGS-1:0]  pending;

    modport master (
        output in_valid, rsrc_in, rdst_in, imm_in, flag_type, imm_mode,
        output wr_done_valid, wr_done_idx, out_ready,
        input  in_ready, out_valid, rsrc_sel, rdst_sel, rdst_wen, imm_out,
        input  stall_hazard, pending
    );

    modport slave (
        input  in_valid, rsrc_in, rdst_in, imm_in, flag_type, imm_mode,
        input  wr_done_valid, wr_done_idx, out_ready,
        output in_ready, out_valid, rsrc_sel, rdst_sel, rdst_wen, imm_out,
        output stall_hazard, pending
    );
endinterface

// File: rtl/decode_stage.sv
// Registered decode stage: turns raw fields into read selects, a one-hot write enable and an
// extended immediate, stalling on reads or writes of registers with an outstanding write.
module decode_stage #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned DATA_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    localparam int unsigned REG_W = $clog2(NREGS);

    logic              out_valid_q, out_valid_d;
    logic [REG_W:0]    rsrc_sel_q, rsrc_sel_d;
    logic [REG_W:0]    rdst_sel_q, rdst_sel_d;
    logic [NREGS-1:0]  rdst_wen_q, rdst_wen_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [NREGS-1:0]  pending_q, pending_d;

    logic [NREGS-1:0]  clear_mask, set_mask, eff_pending, dst_onehot;
    logic              nowrite, stall, ready, accept;
    logic [DATA_W-1:0] imm_ext;

    // A retire in the same cycle already frees its register for the hazard check.
    always_comb begin
        nowrite    = (bus.flag_type == 4'b1000) || (bus.flag_type == 4'b1100);
        dst_onehot = '0;
        dst_onehot[bus.rdst_in] = 1'b1;
        clear_mask = '0;
        if (bus.wr_done_valid) begin
            clear_mask[bus.wr_done_idx] = 1'b1;
        end
        eff_pending = pending_q & ~clear_mask;
        stall       = bus.in_valid & (eff_pending[bus.rsrc_in] | eff_pending[bus.rdst_in]);
        ready       = ~stall & (~out_valid_q | bus.out_ready);
        accept      = bus.in_valid & ready;
        set_mask    = (accept && !nowrite) ? dst_onehot : '0;
        pending_d   = (pending_q & ~clear_mask) | set_mask;
    end

    always_comb begin
        case (bus.imm_mode)
            2'b01:   imm_ext = {{(DATA_W-IMM_W){1'b0}}, bus.imm_in};
            2'b10:   imm_ext = {bus.imm_in, {(DATA_W-IMM_W){1'b0}}};
            default: imm_ext = {{(DATA_W-IMM_W){bus.imm_in[IMM_W-1]}}, bus.imm_in};
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rsrc_sel_d  = rsrc_sel_q;
        rdst_sel_d  = rdst_sel_q;
        rdst_wen_d  = rdst_wen_q;
        imm_d       = imm_q;
        if (accept) begin
            out_valid_d = 1'b1;
            rsrc_sel_d  = {1'b0, bus.rsrc_in} + (REG_W+1)'(1);
            rdst_sel_d  = nowrite ? '0 : {1'b0, bus.rdst_in} + (REG_W+1)'(1);
            rdst_wen_d  = nowrite ? '0 : dst_onehot;
            imm_d       = imm_ext;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rsrc_sel_q  <= '0;
            rdst_sel_q  <= '0;
            rdst_wen_q  <= '0;
            imm_q       <= '0;
            pending_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rsrc_sel_q  <= rsrc_sel_d;
            rdst_sel_q  <= rdst_sel_d;
            rdst_wen_q  <= rdst_wen_d;
            imm_q       <= imm_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.stall_hazard = stall;
    assign bus.out_valid    = out_valid_q;
    assign bus.rsrc_sel     = rsrc_sel_q;
    assign bus.rdst_sel     = rdst_sel_q;
    assign bus.rdst_wen     = rdst_wen_q;
    assign bus.imm_out      = imm_q;
    assign bus.pending      = pending_q;
endmodule
